// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one W-bit adder among NREQ requesters.
// A one-entry result register (EMPTY/FULL) feeds a valid/ready response port.

module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   op_a,
    input  logic [NREQ*W-1:0]   op_b,
    output logic [NREQ-1:0]     gnt,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_sum,
    output logic                rsp_ovf,
    output logic [CNTW-1:0]     ovf_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [W-1:0]    r_sum;
    logic            r_ovf;
    logic [CNTW-1:0] r_ovfCount;

    logic            w_canIssue;
    logic            w_found;
    logic            w_grant;
    logic [IDW-1:0]  w_winner;
    logic [IDW-1:0]  w_nextPtr;
    int              w_scanIdx;
    logic [W-1:0]    w_opA;
    logic [W-1:0]    w_opB;
    logic [W:0]      w_sum;

    // Scan req starting at the pointer and wrapping; the first set bit wins.
    always_comb begin
        w_found   = 1'b0;
        w_winner  = '0;
        w_scanIdx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_scanIdx = int'(r_ptr) + k;
            if (w_scanIdx >= NREQ) begin
                w_scanIdx = w_scanIdx - NREQ;
            end
            if (!w_found && req[w_scanIdx]) begin
                w_found  = 1'b1;
                w_winner = IDW'(w_scanIdx);
            end
        end
    end

    assign w_canIssue = (r_state == EMPTY) || rsp_ready;
    assign w_grant    = !rst && w_canIssue && w_found;
    assign w_nextPtr  = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;

    always_comb begin
        gnt = '0;
        if (w_grant) begin
            gnt[w_winner] = 1'b1;
        end
    end

    assign w_opA = op_a[w_winner*W +: W];
    assign w_opB = op_b[w_winner*W +: W];
    assign w_sum = {1'b0, w_opA} + {1'b0, w_opB};

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY:   if (w_grant) w_nextState = FULL;
            FULL:    if (rsp_ready && !w_grant) w_nextState = EMPTY;
            default: w_nextState = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The result register reloads on any grant; an accept without a grant
    // only empties the FSM and leaves the old payload in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_id  <= '0;
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (w_grant) begin
            r_ptr <= w_nextPtr;
            r_id  <= w_winner;
            r_sum <= w_sum[W-1:0];
            r_ovf <= w_sum[W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovfCount <= '0;
        end else if (rsp_valid && rsp_ready && r_ovf && (r_ovfCount != {CNTW{1'b1}})) begin
            r_ovfCount <= r_ovfCount + 1'b1;
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign rsp_ovf   = r_ovf;
    assign ovf_count = r_ovfCount;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (NREQ=4, W=4, CNTW=8).
// Inputs change 1ns after the rising edge; outputs are checked a further 1ns later.

module tb_adder_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_sum;
    logic        rsp_ovf;
    logic [7:0]  ovf_count;

    int checks = 0;
    int errors = 0;

    adder_share_arbiter #(.NREQ(4), .W(4), .IDW(2), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf), .ovf_count(ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task tick();
        @(posedge clk);
        #1;
    endtask

    task setOp(input int idx, input logic [3:0] a, input logic [3:0] b);
        op_a[idx*4 +: 4] = a;
        op_b[idx*4 +: 4] = b;
    endtask

    task doReset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task test_reset();
        rst = 1'b1; req = 4'b1111; rsp_ready = 1'b1; op_a = '0; op_b = '0;
        #7;
        checks++;
        if (gnt !== 4'b0000 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 4'd0
            || rsp_ovf !== 1'b0 || ovf_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: gnt=%b valid=%b id=%0d sum=%0h ovf=%b cnt=%0d, want all 0",
                     gnt, rsp_valid, rsp_id, rsp_sum, rsp_ovf, ovf_count);
        end
        tick();
        rst = 1'b0; req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_after_reset: gnt=%b valid=%b, want 0000/0", gnt, rsp_valid);
            end
        end
        // Load a pending overflowing result, then reset mid-cycle.
        setOp(0, 4'd9, 4'd9); req = 4'b0001; rsp_ready = 1'b0;
        tick();
        req = 4'b0000;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_ovf !== 1'b1 || rsp_sum !== 4'd2) begin
            errors++;
            $display("[TB] FAIL pre_reset_load: valid=%b ovf=%b sum=%0h, want 1/1/2", rsp_valid, rsp_ovf, rsp_sum);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 4'd0
            || rsp_ovf !== 1'b0 || ovf_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: gnt=%b valid=%b id=%0d sum=%0h ovf=%b cnt=%0d, want all 0",
                     gnt, rsp_valid, rsp_id, rsp_sum, rsp_ovf, ovf_count);
        end
        tick();
        rst = 1'b0;
    endtask

    task test_single();
        setOp(2, 4'd3, 4'd5); req = 4'b0100; rsp_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL single_gnt: got %b want 0100", gnt);
        end
        tick();
        req = 4'b0000;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 4'd8 || rsp_ovf !== 1'b0 || ovf_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL single_rsp: valid=%b id=%0d sum=%0h ovf=%b cnt=%0d, want 1/2/8/0/0",
                     rsp_valid, rsp_id, rsp_sum, rsp_ovf, ovf_count);
        end
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_gnt_drop: got %b want 0000", gnt);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drain: valid=%b want 0", rsp_valid);
        end
    endtask

    task test_overflow();
        // Pointer is 3 here; requester 0 is the only one pending.
        setOp(0, 4'd9, 4'd9); req = 4'b0001; rsp_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL ovf_gnt: got %b want 0001", gnt);
        end
        tick();
        req = 4'b0000;
        checks++;
        if (rsp_sum !== 4'd2 || rsp_ovf !== 1'b1 || rsp_id !== 2'd0 || ovf_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL ovf_rsp: sum=%0h ovf=%b id=%0d cnt=%0d, want 2/1/0/0", rsp_sum, rsp_ovf, rsp_id, ovf_count);
        end
        tick();
        checks++;
        if (ovf_count !== 8'd1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_count_one: cnt=%0d valid=%b, want 1/0", ovf_count, rsp_valid);
        end
        // 254 back-to-back grants plus one final accept lift the count to 255.
        req = 4'b0001;
        for (int i = 0; i < 254; i++) tick();
        req = 4'b0000;
        tick();
        checks++;
        if (ovf_count !== 8'd255) begin
            errors++;
            $display("[TB] FAIL ovf_sat_reach: cnt=%0d want 255", ovf_count);
        end
        req = 4'b0001;
        for (int i = 0; i < 46; i++) tick();
        req = 4'b0000;
        tick();
        checks++;
        if (ovf_count !== 8'd255) begin
            errors++;
            $display("[TB] FAIL ovf_sat_hold: cnt=%0d want 255", ovf_count);
        end
    endtask

    task test_round_robin();
        logic [3:0] expGnt;
        int         expId;
        doReset();
        for (int i = 0; i < 4; i++) setOp(i, 4'(i), 4'(i + 1));
        req = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expId  = k % 4;
            expGnt = 4'b0001 << expId;
            #1;
            checks++;
            if (gnt !== expGnt) begin
                errors++;
                $display("[TB] FAIL rr_gnt[%0d]: got %b want %b", k, gnt, expGnt);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(expId) || rsp_sum !== 4'(2 * expId + 1)) begin
                errors++;
                $display("[TB] FAIL rr_rsp[%0d]: valid=%b id=%0d sum=%0h, want 1/%0d/%0h",
                         k, rsp_valid, rsp_id, rsp_sum, expId, 2 * expId + 1);
            end
        end
        // Pointer now sits at 1: requester 3 wins before requester 0.
        req = 4'b1001;
        #1;
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL rr_1001_first: got %b want 1000", gnt);
        end
        tick();
        checks++;
        if (rsp_id !== 2'd3 || rsp_sum !== 4'd7) begin
            errors++;
            $display("[TB] FAIL rr_1001_rsp3: id=%0d sum=%0h, want 3/7", rsp_id, rsp_sum);
        end
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL rr_1001_second: got %b want 0001", gnt);
        end
        tick();
        req = 4'b0000;
        checks++;
        if (rsp_id !== 2'd0 || rsp_sum !== 4'd1 || rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rr_1001_rsp0: id=%0d sum=%0h valid=%b, want 0/1/1", rsp_id, rsp_sum, rsp_valid);
        end
        tick();
    endtask

    task test_back_pressure();
        // Pointer is 1; only requester 0 asks, so it wins after wrapping.
        setOp(0, 4'd1, 4'd2); req = 4'b0001; rsp_ready = 1'b0;
        tick();
        setOp(1, 4'd4, 4'd6); req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (gnt !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 4'd3 || rsp_ovf !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_stall[%0d]: gnt=%b valid=%b id=%0d sum=%0h ovf=%b, want 0000/1/0/3/0",
                         i, gnt, rsp_valid, rsp_id, rsp_sum, rsp_ovf);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL bp_release_gnt: got %b want 0010", gnt);
        end
        tick();
        req = 4'b0000;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 4'hA || rsp_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_next_rsp: valid=%b id=%0d sum=%0h ovf=%b, want 1/1/a/0",
                     rsp_valid, rsp_id, rsp_sum, rsp_ovf);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_drain: valid=%b want 0", rsp_valid);
        end
    endtask

    task test_boundary();
        logic [3:0] va   [3] = '{4'hF, 4'hF, 4'h0};
        logic [3:0] vb   [3] = '{4'h1, 4'h0, 4'h0};
        logic [3:0] vSum [3] = '{4'h0, 4'hF, 4'h0};
        logic       vOvf [3] = '{1'b1, 1'b0, 1'b0};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setOp(3, va[i], vb[i]); req = 4'b1000;
            #1;
            checks++;
            if (gnt !== 4'b1000) begin
                errors++;
                $display("[TB] FAIL bound_gnt[%0d]: got %b want 1000", i, gnt);
            end
            tick();
            req = 4'b0000;
            checks++;
            if (rsp_sum !== vSum[i] || rsp_ovf !== vOvf[i] || rsp_id !== 2'd3) begin
                errors++;
                $display("[TB] FAIL bound_sum[%0d]: sum=%0h ovf=%b id=%0d, want %0h/%b/3",
                         i, rsp_sum, rsp_ovf, rsp_id, vSum[i], vOvf[i]);
            end
            tick();
        end
        checks++;
        if (ovf_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL bound_count: cnt=%0d want 1", ovf_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_back_pressure();
        test_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one W-bit unsigned adder among NREQ requesters.
- Each cycle it grants at most one requester and captures that requester's operands.
- The registered result is returned with requester ID and carry-out overflow flag through a valid/ready response port.
- Sits between the per-channel request logic and the shared arithmetic datapath; replaces per-channel adders and their overflow-prone direct assigns.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- W, 4, operand and sum width in bits.
- IDW, 2, requester ID width; must equal ceil(log2(NREQ)).
- CNTW, 8, width of the saturating overflow event counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NREQ  request vector; bit i high = requester i has an operation pending.
- op_a  input  NREQ*W  packed operand A; requester i in bits [i*W +: W].
- op_b  input  NREQ*W  packed operand B; same packing as op_a.
- gnt  output  NREQ  one-hot grant, combinational; all zero when no grant occurs.
- rsp_valid  output  1  result register holds an unconsumed result.
- rsp_ready  input  1  consumer accepts the result this cycle.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_sum  output  W  low W bits of op_a + op_b.
- rsp_ovf  output  1  carry-out of the W-bit unsigned add.
- ovf_count  output  CNTW  saturating count of accepted results with rsp_ovf = 1.

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_ovf=0, ovf_count=0, round-robin pointer ptr=0, FSM=EMPTY.
- gnt is 0 while rst is high.
- FSM states: EMPTY and FULL; encoding is fully decoded, with no unreachable states.
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on rsp_ready with no grant.
  - FULL -> FULL on stall (rsp_ready=0) or on rsp_ready with a grant.
- can_issue = (state==EMPTY) | rsp_ready.
- A grant occurs iff can_issue & (req != 0).
- Winner: first set bit of req scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
- gnt[winner]=1 in the same cycle; operands are sampled at that clock edge.
- On grant edge:
  - rsp_id <= winner.
  - {rsp_ovf, rsp_sum} <= zero-extended op_a[winner] + op_b[winner], computed at W+1 bits.
  - rsp_valid <= 1.
  - ptr <= winner+1, wrapping to 0 at NREQ.
- Latency: result is visible on rsp_* one cycle after gnt. Throughput is one result per cycle while rsp_ready is held high.
- Back-pressure: when FULL and rsp_ready=0, gnt=0, rsp_* hold stable, and ptr holds.
- Simultaneous accept and grant: the old result is consumed and the new result loads on the same edge, with no bubble.
- ovf_count increments on each edge where rsp_valid & rsp_ready & rsp_ovf. It saturates at 2^CNTW-1 and never wraps.
- Requester protocol:
  - Hold req and operands stable until gnt is seen.
  - Drop req, or present the next operation, in the cycle after gnt.
  - A req bit high in a grant cycle for a non-winner stays pending.
- Deassertion of req while not granted is allowed; the arbiter holds no per-requester state.
- Reset mid-operation: a pending result is discarded without being counted, and ptr returns to 0.
- All outputs are assigned on every path: no latches, a single driver per signal, and defaults on every case statement.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle with rsp_valid=1 -> all outputs 0 immediately; after release with req=0, gnt stays 0 and rsp_valid stays 0.
- Single request: req=4'b0100, A2=4'd3, B2=4'd5, rsp_ready=1 -> gnt=4'b0100 for one cycle; next cycle rsp_valid=1, rsp_id=2, rsp_sum=8, rsp_ovf=0, ovf_count unchanged.
- Overflow and saturation: A0=4'd9, B0=4'd9 -> rsp_sum=4'd2, rsp_ovf=1, ovf_count=1 after accept. Force 300 overflowing accepts with CNTW=8 -> ovf_count holds at 255.
- Round-robin fairness: req=4'b1111 held, rsp_ready=1 from reset -> grant order 0,1,2,3,0,... with one result per cycle. Then req=4'b1001 with ptr=1 -> winner 3, then 0.
- Back-pressure: FULL with rsp_ready=0 for 3 cycles, req=4'b0010 -> gnt=0 and rsp_* stable for 3 cycles. On the cycle rsp_ready=1 -> gnt=4'b0010, and the new result appears the next cycle with no bubble.
- Boundary sums: A=4'hF, B=4'h1 -> sum 0, ovf 1. A=4'hF, B=4'h0 -> sum F, ovf 0. A=0, B=0 -> sum 0, ovf 0.
